alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes the low 32 bits of a 32x32 multiply (RV32M MUL semantics) using the shared 32-bit ALU, by shift-and-add.
- Drives the ALU operation and operand inputs, captures the ALU result, and reports completion through a start/busy/done handshake.
- Sits beside the ALU in the execute stage. While busy_o=1 the core stalls and grants the ALU exclusively to this block.

Parameters:
- WIDTH, 32, operand/product width; the iteration count equals WIDTH.
- OP_ADD, 4'b0000, ALU operation code for addition.
- OP_SLL, 4'b0110, ALU operation code for logical shift left.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- multiplicand_i  input  WIDTH  operand A; latched on accept.
- multiplier_i  input  WIDTH  operand B; latched on accept.
- busy_o  output  1  high whenever state is not IDLE.
- done_o  output  1  one-cycle completion pulse.
- product_o  output  WIDTH  low WIDTH bits of the product; held until the next accept.
- alu_op_o  output  4  ALU operation select.
- alu_a_o  output  WIDTH  ALU operand A.
- alu_b_o  output  WIDTH  ALU operand B.
- alu_result_i  input  WIDTH  combinational ALU result.

Behaviour:
- Internal registers: mcand, mplier, acc, count (6 bits), state.
- States: IDLE, BIT, SHIFT, DONE.
- Reset: state=IDLE and all registers cleared. Outputs busy_o=0, done_o=0, product_o=0, alu_op_o=OP_ADD, alu_a_o=0, alu_b_o=0. Reset mid-operation aborts immediately; no done_o is produced.
- Accept (IDLE, start_i=1 at rising edge E0): mcand<=multiplicand_i, mplier<=multiplier_i, acc<=0, count<=0, state<=BIT.
- start_i is ignored in BIT, SHIFT and DONE. It is not queued.
- BIT, mplier[0]=1:
  - drive alu_op_o=OP_ADD, alu_a_o=acc, alu_b_o=mcand;
  - acc<=alu_result_i; next state SHIFT.
- BIT, mplier[0]=0:
  - perform the SHIFT action in this same cycle (zero bits cost 1 cycle).
- SHIFT action:
  - drive alu_op_o=OP_SLL, alu_a_o=mcand, alu_b_o=1;
  - mcand<=alu_result_i, mplier<=mplier>>1, count<=count+1.
  - If count==WIDTH-1, go to DONE with product_o<=acc; otherwise go to BIT.
- DONE: done_o=1 for exactly this cycle, then return to IDLE. The earliest possible new accept is the edge ending the first IDLE cycle.
- In IDLE and DONE the ALU outputs are driven OP_ADD/0/0.
- Arithmetic: all ALU results wrap modulo 2^WIDTH. Bits shifted out of mcand are discarded. Signed and unsigned low-word products are identical; no sign handling is performed.
- Latency (no optional feature): 32 + popcount(multiplier) cycles spent in BIT/SHIFT. DONE is entered at edge E(32+popcount). Worst case is 64 cycles for multiplier 0xFFFFFFFF.
- product_o holds its value after DONE and through IDLE until the next accept. It is not cleared by accept.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- When defined:
  - On accept, if multiplier_i==0, go directly to DONE with product_o<=0; done_o is high in the cycle after E0.
  - In the SHIFT action, also go to DONE when the shifted mplier is zero. Latency becomes (index of the highest set bit + 1) + popcount.
- When undefined: always process all WIDTH bits, giving the deterministic latency above.

Test Plan:
- 7 x 6 with the feature off -> done_o pulses when DONE is entered at E34 (32 + popcount(6)=2). product_o=42. busy_o is high from E0 until DONE exits.
- 0xFFFFFFFF x 0xFFFFFFFF -> product_o=0x00000001 after 64 BIT/SHIFT cycles. The ALU is observed alternating OP_ADD/OP_SLL.
- 0x00010000 x 0x00010000 -> product_o=0x00000000 (wrap). Then 0x12345678 x 1 -> 0x12345678.
- start_i=1 held for the entire 3 x 5 operation -> exactly one done_o pulse with product_o=15. A re-accept occurs only after an IDLE cycle.
- Reset asserted mid-operation (at E10 of 9 x 9) -> all outputs return to their reset values immediately with no done_o. A subsequent 9 x 9 gives 81.
- MUL_EARLY_TERM_EN defined: 3 x 5 -> DONE entered at E5, product_o=15. 8 x 0 -> done_o in the cycle after E0, product_o=0.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: low-word 32x32 multiply (RV32M MUL) done by shift-and-add
// on the shared execute-stage ALU. The core stalls while busy_o is high and
// lends the ALU to this block; the result comes back combinationally on
// alu_result_i in the same cycle.
// Optional feature: define MUL_EARLY_TERM_EN to stop as soon as the remaining
// multiplier bits are all zero (including an immediate finish for a zero
// multiplier). Without it every operand takes the full WIDTH iterations.
module alu_mul_sequencer #(
   parameter int         WIDTH  = 32,
   parameter logic [3:0] OP_ADD = 4'b0000,
   parameter logic [3:0] OP_SLL = 4'b0110
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [WIDTH-1:0] multiplicand_i,
   input  logic [WIDTH-1:0] multiplier_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] product_o,
   output logic [3:0]       alu_op_o,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   input  logic [WIDTH-1:0] alu_result_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BIT   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [5:0]       count;

   logic do_add;    // BIT cycle with a set multiplier bit: acc += mcand
   logic do_shift;  // shift action: mcand <<= 1, mplier >>= 1, count++
   logic finish;    // the current shift action is the last one

   // Decode this cycle's ALU use from the registered state. The ALU is
   // combinational, so operands must come from current registers, not a
   // next-state register; zero multiplier bits fold the shift into BIT.
   always_comb begin
      do_add   = (state == BIT) && mplier[0];
      do_shift = (state == SHIFT) || ((state == BIT) && !mplier[0]);
      alu_op_o = OP_ADD;
      alu_a_o  = '0;
      alu_b_o  = '0;
      if (do_add) begin
         alu_op_o = OP_ADD;
         alu_a_o  = acc;
         alu_b_o  = mcand;
      end else if (do_shift) begin
         alu_op_o = OP_SLL;
         alu_a_o  = mcand;
         alu_b_o  = WIDTH'(1);
      end
`ifdef MUL_EARLY_TERM_EN
      finish = (count == 6'(WIDTH-1)) || ((mplier >> 1) == '0);
`else
      finish = (count == 6'(WIDTH-1));
`endif
   end

   // Sequencer FSM with registered busy/done/product.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         product_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  mcand  <= multiplicand_i;
                  mplier <= multiplier_i;
                  acc    <= '0;
                  count  <= '0;
                  busy_o <= 1'b1;
`ifdef MUL_EARLY_TERM_EN
                  if (multiplier_i == '0) begin
                     state     <= DONE;
                     product_o <= '0;
                     done_o    <= 1'b1;
                  end else begin
                     state <= BIT;
                  end
`else
                  state <= BIT;
`endif
               end
            end
            DONE: begin
               // start_i is deliberately not looked at here; a new request
               // can only be accepted from IDLE
               state  <= IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
            end
            default: begin
               if (do_add) begin
                  acc   <= alu_result_i;
                  state <= SHIFT;
               end else if (do_shift) begin
                  mcand  <= alu_result_i;
                  mplier <= mplier >> 1;
                  count  <= count + 6'd1;
                  if (finish) begin
                     // acc already holds the final sum: any add for this
                     // bit happened in the preceding BIT cycle
                     state     <= DONE;
                     product_o <= acc;
                     done_o    <= 1'b1;
                  end else begin
                     state <= BIT;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: stimulus pushes the expected
// product and DONE-entry edge index; a monitor pops on every done_o pulse.
// A small ALU model closes the loop on alu_result_i.
module tb_alu_mul_sequencer;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SLL = 4'b0110;
`ifdef MUL_EARLY_TERM_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] multiplicand_i = '0;
   logic [31:0] multiplier_i = '0;
   logic        busy_o, done_o;
   logic [31:0] product_o, alu_a_o, alu_b_o, alu_result_i;
   logic [3:0]  alu_op_o;

   alu_mul_sequencer dut (
      .clk(clk), .reset(reset), .start_i(start_i),
      .multiplicand_i(multiplicand_i), .multiplier_i(multiplier_i),
      .busy_o(busy_o), .done_o(done_o), .product_o(product_o),
      .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_result_i(alu_result_i)
   );

   always #5 clk = ~clk;

   // reference ALU
   assign alu_result_i = (alu_op_o == OP_ADD) ? alu_a_o + alu_b_o :
                         (alu_op_o == OP_SLL) ? alu_a_o << alu_b_o[4:0] : 32'h0;

   typedef struct {
      logic [31:0] p;
      int          lat;
      time         t0;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] p;
      int          lat_full;
      int          lat_et;
      bit          alt;
   } vec_t;

   exp_t sb[$];
   int   compared = 0;
   int   mismatched = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // monitor: every done_o pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (!reset && done_o) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: got done_o=1 at %0t, expected none", $time);
         end else begin
            exp_t e;
            int   lat;
            e   = sb.pop_front();
            lat = int'(($time - e.t0 - 5) / 10);
            check("product", product_o, e.p);
            check("done_edge", 32'(lat), 32'(e.lat));
            check("busy_in_done", {31'b0, busy_o}, 32'd1);
         end
      end
   end

   // wait (bounded) for done_o; optionally check ADD/SLL alternation
   task automatic wait_done(input bit alt);
      bit seen = 1'b0;
      int i = 0;
      while (!seen && i < 200) begin
         @(negedge clk);
         if (i == 0) check("busy_after_accept", {31'b0, busy_o}, 32'd1);
         if (done_o) seen = 1'b1;
         else if (alt) begin
            check("alu_op_alt", {28'b0, alu_op_o}, (i % 2 == 0) ? {28'b0, OP_ADD} : {28'b0, OP_SLL});
            if (i % 2 == 1) check("alu_b_shift", alu_b_o, 32'd1);
         end
         i++;
      end
      if (!seen) begin
         compared++;
         mismatched++;
         $display("FAIL done_timeout: got no done_o in 200 cycles, expected one");
         sb.delete();
      end
   endtask

   task automatic run_op(input vec_t v);
      exp_t e;
      @(negedge clk);
      multiplicand_i = v.a;
      multiplier_i   = v.b;
      start_i        = 1'b1;
      @(posedge clk);
      e.p   = v.p;
      e.lat = ET ? v.lat_et : v.lat_full;
      e.t0  = $time;
      sb.push_back(e);
      #1 start_i = 1'b0;
      wait_done(v.alt);
      @(posedge clk);
      #1 check("busy_after_done", {31'b0, busy_o}, 32'd0);
   endtask

   vec_t vecs[7] = '{
      '{32'd7,        32'd6,        32'd42,         34, 5,  1'b0},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   64, 64, 1'b1},
      '{32'h00010000, 32'h00010000, 32'h00000000,   33, 18, 1'b0},
      '{32'h12345678, 32'h00000001, 32'h12345678,   33, 2,  1'b0},
      '{32'hDEADBEEF, 32'h00000010, 32'hEADBEEF0,   33, 6,  1'b0},
      '{32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB,   35, 6,  1'b0},
      '{32'h00000008, 32'h00000000, 32'h00000000,   32, 0,  1'b0}
   };

   initial begin
      exp_t e;
      vec_t v;
      bit   seen;
      #1;
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_product", product_o, 32'd0);
      check("rst_alu_op", {28'b0, alu_op_o}, {28'b0, OP_ADD});
      check("rst_alu_a", alu_a_o, 32'd0);
      check("rst_alu_b", alu_b_o, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[k]) run_op(vecs[k]);

      // start_i held across the whole 3 x 5: one done, IDLE gap, then re-accept
      @(negedge clk);
      multiplicand_i = 32'd3;
      multiplier_i   = 32'd5;
      start_i        = 1'b1;
      @(posedge clk);
      e.p = 32'd15; e.lat = ET ? 5 : 34; e.t0 = $time;
      sb.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done_o) seen = 1'b1;
      end
      check("hold_done_seen", {31'b0, seen}, 32'd1);
      @(posedge clk);
      #1 check("hold_idle_gap_busy", {31'b0, busy_o}, 32'd0);
      @(posedge clk);
      e.t0 = $time;
      sb.push_back(e);
      #1 check("hold_reaccept_busy", {31'b0, busy_o}, 32'd1);
      start_i = 1'b0;
      wait_done(1'b0);
      repeat (3) @(negedge clk);

      // reset at E10 of 9 x 9 aborts without a done pulse
      @(negedge clk);
      multiplicand_i = 32'd9;
      multiplier_i   = 32'd9;
      start_i        = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("abort_busy", {31'b0, busy_o}, 32'd0);
      check("abort_done", {31'b0, done_o}, 32'd0);
      check("abort_product", product_o, 32'd0);
      check("abort_alu_op", {28'b0, alu_op_o}, {28'b0, OP_ADD});
      check("abort_alu_a", alu_a_o, 32'd0);
      check("abort_alu_b", alu_b_o, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_still_idle", {31'b0, busy_o}, 32'd0);

      v = '{32'd9, 32'd9, 32'd81, 34, 6, 1'b0};
      run_op(v);
      repeat (5) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
